// File: rtl/macc_stream_pkg.sv
// Shared constants and helpers for the framed multiply-accumulate engine.
package macc_stream_pkg;

    // Legal range for the depth of the multiplier register chain.
    localparam int MULT_STAGES_MIN = 1;
    localparam int MULT_STAGES_MAX = 4;

    // Saturation constants are built at this width and sliced down by the user.
    localparam int SAT_CONST_WIDTH = 128;

    typedef logic [SAT_CONST_WIDTH-1:0] sat_const_t;

    // Largest representable value: all-ones when unsigned, 0x7F..F when signed.
    function automatic sat_const_t sat_max(input int width, input bit is_signed);
        sat_const_t v;
        int         ones;
        v    = '0;
        ones = is_signed ? width - 1 : width;
        for (int i = 0; i < SAT_CONST_WIDTH; i++) begin
            if (i < ones) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Smallest representable value: zero when unsigned, 0x80..0 when signed.
    function automatic sat_const_t sat_min(input int width, input bit is_signed);
        sat_const_t v;
        v = '0;
        if (is_signed && width > 0 && width <= SAT_CONST_WIDTH) begin
            v[width-1] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/macc_mult_pipe.sv
// Multiplier followed by a register chain; product, valid and last move together.
module macc_mult_pipe
    import macc_stream_pkg::*;
#(
    parameter int INPUT_WIDTH = 18,
    parameter int STAGES      = 1,
    parameter int SIGNED      = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic [INPUT_WIDTH-1:0]   a,
    input  logic [INPUT_WIDTH-1:0]   b,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [2*INPUT_WIDTH-1:0] out_prod
);

    localparam int PROD_WIDTH = 2 * INPUT_WIDTH;

    logic signed [INPUT_WIDTH-1:0] a_s;
    logic signed [INPUT_WIDTH-1:0] b_s;
    logic signed [PROD_WIDTH-1:0]  prod_signed;
    logic        [PROD_WIDTH-1:0]  prod_unsigned;
    logic        [PROD_WIDTH-1:0]  prod_now;

    logic [STAGES-1:0]     valid_d;
    logic [STAGES-1:0]     valid_q;
    logic [STAGES-1:0]     last_d;
    logic [STAGES-1:0]     last_q;
    logic [PROD_WIDTH-1:0] prod_d [STAGES];
    logic [PROD_WIDTH-1:0] prod_q [STAGES];

    assign a_s = a;
    assign b_s = b;

    // Full-width product; the signed form sign-extends operands to product width.
    always_comb begin
        prod_signed   = a_s * b_s;
        prod_unsigned = a * b;
        if (SIGNED != 0) begin
            prod_now = prod_signed;
        end else begin
            prod_now = prod_unsigned;
        end
    end

    // Shift every stage forward; clear turns all stages into bubbles.
    always_comb begin
        valid_d[0] = in_valid & ~clear;
        last_d[0]  = in_last;
        prod_d[0]  = prod_now;
        for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = valid_q[i-1] & ~clear;
            last_d[i]  = last_q[i-1];
            prod_d[i]  = prod_q[i-1];
        end
    end

    // Only the valid sideband needs a reset; data behind an invalid stage is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data and last flag advance unconditionally alongside their valid bit.
    always_ff @(posedge clk) begin
        last_q <= last_d;
        prod_q <= prod_d;
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_last  = last_q[STAGES-1];
    assign out_prod  = prod_q[STAGES-1];

endmodule

// File: rtl/macc_stream.sv
// Framed multiply-accumulate: sums products over a frame and reports sum plus overflow.
module macc_stream
    import macc_stream_pkg::*;
#(
    parameter int INPUT_WIDTH  = 18,
    parameter int OUTPUT_WIDTH = 40,
    parameter int SIGNED       = 0,
    parameter int SATURATE     = 0,
    parameter int MULT_STAGES  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic [INPUT_WIDTH-1:0]  a,
    input  logic [INPUT_WIDTH-1:0]  b,
    output logic [OUTPUT_WIDTH-1:0] y,
    output logic                    out_valid,
    output logic                    overflow
);

    localparam int PROD_WIDTH = 2 * INPUT_WIDTH;

    localparam sat_const_t SAT_MAX_FULL = sat_max(OUTPUT_WIDTH, SIGNED != 0);
    localparam sat_const_t SAT_MIN_FULL = sat_min(OUTPUT_WIDTH, SIGNED != 0);
    localparam logic [OUTPUT_WIDTH-1:0] SAT_MAX = SAT_MAX_FULL[OUTPUT_WIDTH-1:0];
    localparam logic [OUTPUT_WIDTH-1:0] SAT_MIN = SAT_MIN_FULL[OUTPUT_WIDTH-1:0];

    if (OUTPUT_WIDTH < 2 * INPUT_WIDTH) begin : g_err_out_width
        $error("macc_stream: OUTPUT_WIDTH must be at least 2*INPUT_WIDTH");
    end
    if (OUTPUT_WIDTH > SAT_CONST_WIDTH) begin : g_err_out_wide
        $error("macc_stream: OUTPUT_WIDTH exceeds saturation constant width");
    end
    if (MULT_STAGES < MULT_STAGES_MIN || MULT_STAGES > MULT_STAGES_MAX) begin : g_err_stages
        $error("macc_stream: MULT_STAGES out of range");
    end

    logic                    pipe_valid;
    logic                    pipe_last;
    logic [PROD_WIDTH-1:0]   pipe_prod;

    logic [OUTPUT_WIDTH-1:0] prod_ext;
    logic [OUTPUT_WIDTH:0]   sum_wide;
    logic [OUTPUT_WIDTH-1:0] sum;
    logic [OUTPUT_WIDTH-1:0] acc_result;
    logic                    add_ovf;

    logic [OUTPUT_WIDTH-1:0] acc_d, acc_q;
    logic                    ovf_sticky_d, ovf_sticky_q;
    logic [OUTPUT_WIDTH-1:0] y_d, y_q;
    logic                    out_valid_d, out_valid_q;
    logic                    overflow_d, overflow_q;

    macc_mult_pipe #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .STAGES      (MULT_STAGES),
        .SIGNED      (SIGNED)
    ) u_mult_pipe (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .a         (a),
        .b         (b),
        .out_valid (pipe_valid),
        .out_last  (pipe_last),
        .out_prod  (pipe_prod)
    );

    // One adder plus overflow detect and clamp mux between accumulator and product.
    always_comb begin
        if (SIGNED != 0) begin
            prod_ext = OUTPUT_WIDTH'($signed(pipe_prod));
        end else begin
            prod_ext = OUTPUT_WIDTH'(pipe_prod);
        end
        sum_wide = {1'b0, acc_q} + {1'b0, prod_ext};
        sum      = sum_wide[OUTPUT_WIDTH-1:0];
        if (SIGNED != 0) begin
            add_ovf = (acc_q[OUTPUT_WIDTH-1] == prod_ext[OUTPUT_WIDTH-1]) &&
                      (sum[OUTPUT_WIDTH-1] != acc_q[OUTPUT_WIDTH-1]);
        end else begin
            add_ovf = sum_wide[OUTPUT_WIDTH];
        end
        acc_result = sum;
        if (SATURATE != 0 && add_ovf) begin
            if (SIGNED != 0 && acc_q[OUTPUT_WIDTH-1]) begin
                acc_result = SAT_MIN;
            end else begin
                acc_result = SAT_MAX;
            end
        end
    end

    // Accumulate mid-frame beats; on the last beat publish the sum and restart from zero.
    always_comb begin
        acc_d        = acc_q;
        ovf_sticky_d = ovf_sticky_q;
        y_d          = y_q;
        overflow_d   = overflow_q;
        out_valid_d  = 1'b0;
        if (clear) begin
            acc_d        = '0;
            ovf_sticky_d = 1'b0;
        end else if (pipe_valid) begin
            if (pipe_last) begin
                y_d          = acc_result;
                overflow_d   = ovf_sticky_q | add_ovf;
                out_valid_d  = 1'b1;
                acc_d        = '0;
                ovf_sticky_d = 1'b0;
            end else begin
                acc_d        = acc_result;
                ovf_sticky_d = ovf_sticky_q | add_ovf;
            end
        end
    end

    // Accumulator and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q        <= '0;
            ovf_sticky_q <= 1'b0;
            y_q          <= '0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            ovf_sticky_q <= ovf_sticky_d;
            y_q          <= y_d;
            out_valid_q  <= out_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

endmodule
